pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the five-stage CPU. It produces the 2-bit `condition` code that drives each inter-stage register (IFID, IDEX, EXMEM, MEMWB) and the PC write enable. It detects load-use hazards, resolves taken branches and jumps with flushes, and stretches the pipeline around a data memory that acknowledges late. A timeout FSM and a stall counter sit alongside.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 53 +++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: stage-register condition codes,
// controller FSM states and the bundled control word driven to the pipeline.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] COND_FLUSH = 2'd0;
  localparam logic [1:0] COND_LOAD  = 2'd1;
  localparam logic [1:0] COND_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] ifid;
    logic [1:0] idex;
    logic [1:0] exmem;
    logic [1:0] memwb;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, ifid: COND_FLUSH, idex: COND_FLUSH,
                                   exmem: COND_FLUSH, memwb: COND_FLUSH};
  localparam ctrl_t CTRL_RUN   = '{pc_en: 1'b1, ifid: COND_LOAD, idex: COND_LOAD,
                                   exmem: COND_LOAD, memwb: COND_LOAD};
  localparam ctrl_t CTRL_MEM_STALL = '{pc_en: 1'b0, ifid: COND_HOLD, idex: COND_HOLD,
                                       exmem: COND_HOLD, memwb: COND_FLUSH};
  // Front end frozen, back end bubbled so no store or writeback repeats.
  localparam ctrl_t CTRL_HALTED = '{pc_en: 1'b0, ifid: COND_HOLD, idex: COND_HOLD,
                                    exmem: COND_FLUSH, memwb: COND_FLUSH};

  // Control flow resolution once the data memory is not holding us back;
  // a taken branch beats a load-use hazard, which beats a jump.
  function automatic ctrl_t flow_ctrl(input logic branch_taken,
                                      input logic load_use,
                                      input logic jump);
    ctrl_t c;
    c = CTRL_RUN;
    if (branch_taken) begin
      c.ifid = COND_FLUSH;
      c.idex = COND_FLUSH;
    end else if (load_use) begin
      c.pc_en = 1'b0;
      c.ifid  = COND_HOLD;
      c.idex  = COND_FLUSH;
    end else if (jump) begin
      c.ifid = COND_FLUSH;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: the instruction in ID reads a register that the
// load currently in EX has not yet fetched from memory.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  logic rs_match;
  logic rt_match;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    rs_match = id_uses_rs && (id_rs == ex_rd);
    rt_match = id_uses_rt && (id_rt == ex_rd);
    hazard   = ex_memread && (ex_rd != 5'd0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller: stage-register conditions and PC enable, with a
// memory-wait/timeout FSM and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt,
  output logic             pc_en,
  output logic [1:0]       ifid_cond,
  output logic [1:0]       idex_cond,
  output logic [1:0]       exmem_cond,
  output logic [1:0]       memwb_cond,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout,
  output logic             halted
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0]  stall_q;
  logic              timeout_q;
  logic              load_use;
  logic              timeout_hit;
  logic              enter_wait;
  logic              stall_event;
  ctrl_t             flow;
  ctrl_t             ctrl;

  load_use_detect u_load_use (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .hazard     (load_use)
  );

  always_comb begin
    flow        = flow_ctrl(ex_branch_taken, load_use, id_jump);
    state_d     = state_q;
    ctrl        = CTRL_RESET;
    timeout_hit = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          ctrl    = CTRL_MEM_STALL;
          state_d = ST_MEMWAIT;
        end else begin
          ctrl = flow;
          if (halt) state_d = ST_HALTED;
        end
      end
      ST_MEMWAIT: begin
        if (!mem_ready) begin
          ctrl = CTRL_MEM_STALL;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d     = ST_HALTED;
            timeout_hit = 1'b1;
          end
        end else begin
          ctrl    = flow;
          state_d = halt ? ST_HALTED : ST_RUN;
        end
      end
      ST_HALTED: begin
        ctrl = CTRL_HALTED;
      end
      default: begin
        ctrl    = CTRL_RESET;
        state_d = ST_RUN;
      end
    endcase
    // Stage registers must see bubbles for as long as reset is held.
    if (!reset) ctrl = CTRL_RESET;
    enter_wait  = (state_q != ST_MEMWAIT) && (state_d == ST_MEMWAIT);
    stall_event = !ctrl.pc_en && (state_q != ST_HALTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else if (enter_wait) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_MEMWAIT && !mem_ready && wait_cnt_q != WAIT_MAX) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (stall_event && !(&stall_q)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  // Sticky until reset so software can see why the core stopped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           timeout_q <= 1'b0;
    else if (timeout_hit) timeout_q <= 1'b1;
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_cond    = ctrl.ifid;
  assign idex_cond    = ctrl.idex;
  assign exmem_cond   = ctrl.exmem;
  assign memwb_cond   = ctrl.memwb;
  assign stall_cycles = stall_q;
  assign mem_timeout  = timeout_q;
  assign halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each driven cycle queues its expected
// outputs, and a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_jump, ex_memread, ex_branch_taken;
  logic       mem_req, mem_ready, halt;
  logic       pc_en, mem_timeout, halted;
  logic [1:0] ifid_cond, idex_cond, exmem_cond, memwb_cond;
  logic [3:0] stall_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       jump;
    logic       memread;
    logic [4:0] ex_rd;
    logic       branch;
    logic       mem_req;
    logic       mem_ready;
    logic       halt;
  } stim_t;

  typedef struct {
    string      tag;
    logic       pc;
    logic [1:0] ifid;
    logic [1:0] idex;
    logic [1:0] exmem;
    logic [1:0] memwb;
    int         stall;
    logic       tmo;
    logic       hlt;
  } exp_t;

  exp_t sb[$];

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .halt            (halt),
    .pc_en           (pc_en),
    .ifid_cond       (ifid_cond),
    .idex_cond       (idex_cond),
    .exmem_cond      (exmem_cond),
    .memwb_cond      (memwb_cond),
    .stall_cycles    (stall_cycles),
    .mem_timeout     (mem_timeout),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.id_rs = 5'd0; s.id_rt = 5'd0; s.uses_rs = 1'b0; s.uses_rt = 1'b0;
    s.jump = 1'b0; s.memread = 1'b0; s.ex_rd = 5'd0; s.branch = 1'b0;
    s.mem_req = 1'b0; s.mem_ready = 1'b0; s.halt = 1'b0;
    return s;
  endfunction

  function automatic stim_t lu(input logic [4:0] rd, input logic [4:0] rs);
    stim_t s;
    s = idle();
    s.memread = 1'b1; s.ex_rd = rd; s.id_rs = rs; s.uses_rs = 1'b1;
    return s;
  endfunction

  function automatic stim_t mw(input logic ready);
    stim_t s;
    s = idle();
    s.mem_req = 1'b1; s.mem_ready = ready;
    return s;
  endfunction

  function automatic exp_t ex(input string tag, input logic pc, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] c,
                              input logic [1:0] d, input int stall,
                              input logic tmo, input logic hlt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.ifid = a; e.idex = b; e.exmem = c; e.memwb = d;
    e.stall = stall; e.tmo = tmo; e.hlt = hlt;
    return e;
  endfunction

  task automatic driveInputs(input stim_t s);
    id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rs = s.uses_rs; id_uses_rt = s.uses_rt;
    id_jump = s.jump; ex_memread = s.memread; ex_rd = s.ex_rd;
    ex_branch_taken = s.branch; mem_req = s.mem_req; mem_ready = s.mem_ready;
    halt = s.halt;
  endtask

  task automatic applyStimulus(input stim_t s, input exp_t e);
    driveInputs(s);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".pc"}, 32'(pc_en), 0);
    checkOutput({tag, ".ifid"}, 32'(ifid_cond), 0);
    checkOutput({tag, ".idex"}, 32'(idex_cond), 0);
    checkOutput({tag, ".exmem"}, 32'(exmem_cond), 0);
    checkOutput({tag, ".memwb"}, 32'(memwb_cond), 0);
    checkOutput({tag, ".stall"}, 32'(stall_cycles), 0);
    checkOutput({tag, ".tmo"}, 32'(mem_timeout), 0);
    checkOutput({tag, ".halted"}, 32'(halted), 0);
  endtask

  task automatic doReset(input string tag);
    driveInputs(idle());
    reset = 1'b0;
    #1;
    checkReset(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.tag, ".pc"}, 32'(pc_en), 32'(e.pc));
      checkOutput({e.tag, ".ifid"}, 32'(ifid_cond), 32'(e.ifid));
      checkOutput({e.tag, ".idex"}, 32'(idex_cond), 32'(e.idex));
      checkOutput({e.tag, ".exmem"}, 32'(exmem_cond), 32'(e.exmem));
      checkOutput({e.tag, ".memwb"}, 32'(memwb_cond), 32'(e.memwb));
      checkOutput({e.tag, ".stall"}, 32'(stall_cycles), 32'(e.stall));
      checkOutput({e.tag, ".tmo"}, 32'(mem_timeout), 32'(e.tmo));
      checkOutput({e.tag, ".halted"}, 32'(halted), 32'(e.hlt));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    driveInputs(idle());
    reset = 1'b0;

    // Load-use, r0 exemption, rt path, and priority between hazard sources
    doReset("rst0");
    applyStimulus(lu(5'd5, 5'd5), ex("lu_rs", 1'b0, 2, 0, 1, 1, 0, 1'b0, 1'b0));
    applyStimulus(idle(),         ex("lu_after", 1'b1, 1, 1, 1, 1, 1, 1'b0, 1'b0));
    applyStimulus(lu(5'd0, 5'd0), ex("lu_r0", 1'b1, 1, 1, 1, 1, 1, 1'b0, 1'b0));
    s = idle(); s.memread = 1'b1; s.ex_rd = 5'd7; s.id_rt = 5'd7; s.uses_rt = 1'b1;
    applyStimulus(s,              ex("lu_rt", 1'b0, 2, 0, 1, 1, 1, 1'b0, 1'b0));
    s.uses_rt = 1'b0;
    applyStimulus(s,              ex("lu_rt_unused", 1'b1, 1, 1, 1, 1, 2, 1'b0, 1'b0));
    s = lu(5'd5, 5'd5); s.branch = 1'b1;
    applyStimulus(s,              ex("br_lu", 1'b1, 0, 0, 1, 1, 2, 1'b0, 1'b0));
    s = idle(); s.jump = 1'b1;
    applyStimulus(s,              ex("jump", 1'b1, 0, 1, 1, 1, 2, 1'b0, 1'b0));
    s = lu(5'd9, 5'd9); s.jump = 1'b1;
    applyStimulus(s,              ex("lu_jump", 1'b0, 2, 0, 1, 1, 2, 1'b0, 1'b0));
    applyStimulus(idle(),         ex("lu_end", 1'b1, 1, 1, 1, 1, 3, 1'b0, 1'b0));

    // Memory wait of three cycles, then ready with a branch and with a hazard
    doReset("rst1");
    applyStimulus(mw(1'b0), ex("mw0", 1'b0, 2, 2, 2, 0, 0, 1'b0, 1'b0));
    applyStimulus(mw(1'b0), ex("mw1", 1'b0, 2, 2, 2, 0, 1, 1'b0, 1'b0));
    applyStimulus(mw(1'b0), ex("mw2", 1'b0, 2, 2, 2, 0, 2, 1'b0, 1'b0));
    applyStimulus(mw(1'b1), ex("mw_rdy", 1'b1, 1, 1, 1, 1, 3, 1'b0, 1'b0));
    applyStimulus(idle(),   ex("mw_run", 1'b1, 1, 1, 1, 1, 3, 1'b0, 1'b0));
    applyStimulus(mw(1'b0), ex("mw_b0", 1'b0, 2, 2, 2, 0, 3, 1'b0, 1'b0));
    s = mw(1'b1); s.branch = 1'b1;
    applyStimulus(s,        ex("mw_b_rdy", 1'b1, 0, 0, 1, 1, 4, 1'b0, 1'b0));
    s = lu(5'd4, 5'd4); s.mem_req = 1'b1;
    applyStimulus(s,        ex("mw_lu0", 1'b0, 2, 2, 2, 0, 4, 1'b0, 1'b0));
    s.mem_ready = 1'b1;
    applyStimulus(s,        ex("mw_lu_rdy", 1'b0, 2, 0, 1, 1, 5, 1'b0, 1'b0));
    applyStimulus(idle(),   ex("mw_end", 1'b1, 1, 1, 1, 1, 6, 1'b0, 1'b0));

    // Timeout with TIMEOUT=4: four MEMWAIT cycles, then halted for good
    doReset("rst2");
    applyStimulus(mw(1'b0), ex("to_run", 1'b0, 2, 2, 2, 0, 0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++)
      applyStimulus(mw(1'b0), ex($sformatf("to_w%0d", i), 1'b0, 2, 2, 2, 0, i + 1, 1'b0, 1'b0));
    applyStimulus(mw(1'b0), ex("to_halt", 1'b0, 2, 2, 0, 0, 5, 1'b1, 1'b1));
    s = mw(1'b1); s.halt = 1'b1; s.branch = 1'b1;
    applyStimulus(s,        ex("to_stay", 1'b0, 2, 2, 0, 0, 5, 1'b1, 1'b1));

    // Halt, then asynchronous reset in the middle of a cycle
    doReset("rst3");
    applyStimulus(lu(5'd2, 5'd2), ex("h_lu", 1'b0, 2, 0, 1, 1, 0, 1'b0, 1'b0));
    s = idle(); s.halt = 1'b1;
    applyStimulus(s,      ex("h_req", 1'b1, 1, 1, 1, 1, 1, 1'b0, 1'b0));
    applyStimulus(idle(), ex("h_1", 1'b0, 2, 2, 0, 0, 1, 1'b0, 1'b1));
    applyStimulus(lu(5'd2, 5'd2), ex("h_2", 1'b0, 2, 2, 0, 0, 1, 1'b0, 1'b1));
    #2;
    reset = 1'b0;
    #1;
    checkReset("h_async_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(idle(), ex("h_after_rst", 1'b1, 1, 1, 1, 1, 0, 1'b0, 1'b0));

    // Stall counter saturation with CNT_W=4
    doReset("rst4");
    for (int i = 0; i < 20; i++)
      applyStimulus(lu(5'd3, 5'd3), ex($sformatf("sat%0d", i), 1'b0, 2, 0, 1, 1,
                                       (i < 15) ? i : 15, 1'b0, 1'b0));
    applyStimulus(idle(), ex("sat_end", 1'b1, 1, 1, 1, 1, 15, 1'b0, 1'b0));

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) checkOutput("sb_drain", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
